stonet_block_sequencer: RTL and testbench
=========================================

// Module: stonet_block_sequencer
// PURPOSE
// - Block-level scheduler for the stonet hidden-neuron array: sequences each image block through
//   weight accumulation, pipeline drain, spike generation, error/true feedback and block commit.
// - Drives the shared neuron controls gen_spike, new_block, train, outaddr, errspikes, truespikes
//   and the weight-memory read address. One instance serves every hidden neuron in a layer.
// PARAMETERS
// - N_ACC      128  accumulation cycles per block (one weight-memory read per cycle)
// - DRAIN_CYC  4    idle cycles after the last read: memory latency 1 + neuron adder pipeline 3
// - SPIKE_CYC  3    gen_spike high cycles (mul -> spikeprob -> compare in the neuron)
// - N_OUT      10   output-layer addresses streamed in feedback (max 15)
// - AW         7    weight address width, 2**AW >= N_ACC
// PORTS
// - clk          in   1   clock
// - resetn       in   1   synchronous active-low reset
// - start        in   1   begin a run; sampled only in IDLE
// - num_blocks   in   16  blocks in the run, sampled with start; 0 is treated as 1
// - train_mode   in   1   sampled with start, held on train for the whole run
// - abort        in   1   stop the run; takes priority over everything except reset
// - err_vec      in   10  output error spikes of the current block, one bit per output address
// - true_vec     in   10  output target spikes of the current block
// - w_rd_en      out  1   weight-memory read strobe
// - w_addr       out  AW  weight-memory read address
// - gen_spike    out  1   neuron spike-generation enable
// - new_block    out  1   one-cycle block commit pulse to the neurons
// - train        out  1   neuron training enable
// - outaddr      out  4   feedback weight select
// - errspikes    out  1   err_vec bit for outaddr, gated to the FEEDBACK state
// - truespikes   out  1   true_vec bit for outaddr, gated to the FEEDBACK state
// - busy         out  1   high in every state except IDLE
// - done         out  1   one-cycle pulse after the last block's commit
// BEHAVIOUR
// - All outputs are registered. Reset values: all outputs 0, except outaddr = 4'hF (neuron selects
//   a feedback weight of 0). Reset returns the FSM to IDLE and clears the counters.
// - FSM states: IDLE -> ACCUM -> DRAIN -> SPIKE -> FEEDBACK -> COMMIT, then back to ACCUM, or to
//   IDLE when the last block completes.
//   - IDLE: start=1 latches num_blocks (0 becomes 1) and train_mode, clears blk_cnt, enters ACCUM
//     next cycle. start is ignored in every other state.
//   - ACCUM: w_rd_en=1, w_addr runs 0..N_ACC-1, exactly N_ACC cycles.
//   - DRAIN: DRAIN_CYC cycles, all strobes low.
//   - SPIKE: gen_spike=1 for SPIKE_CYC consecutive cycles.
//   - FEEDBACK, entry: latch err_vec/true_vec into shadow registers (inputs may change after this).
//     Then N_OUT cycles with outaddr = 0..N_OUT-1, errspikes = err_sh[outaddr],
//     truespikes = true_sh[outaddr].
//   - COMMIT: new_block=1 for exactly one cycle, blk_cnt += 1. If blk_cnt reaches the latched count,
//     pulse done in the same cycle and go to IDLE; otherwise go to ACCUM.
// - Outside FEEDBACK: errspikes = truespikes = 0 and outaddr = 4'hF. The neuron accumulates feedback
//   on every cycle that is not new_block, so this gating is mandatory.
// - gen_spike, new_block and w_rd_en are never high in the same cycle. new_block is never high
//   outside COMMIT.
// - Block period = N_ACC + DRAIN_CYC + SPIKE_CYC + N_OUT + 1 cycles (default 146). The first
//   w_rd_en comes 1 cycle after the start sample.
// - abort in any non-IDLE state: the next state is COMMIT with a forced new_block pulse (clears the
//   neuron accumulators), then IDLE. done is not pulsed and blk_cnt is not compared.
// - abort in IDLE: no effect. Simultaneous start and abort in IDLE: start wins.
// - train is held constant from the start sample until the return to IDLE, then cleared to 0.
// - Counters use saturating compare (==), never wrap-dependent. num_blocks=16'hFFFF is legal.
// STRUCTURE
// - Shared package stonet_pkg: state enum (IDLE, ACCUM, DRAIN, SPIKE, FEEDBACK, COMMIT),
//   OUTADDR_IDLE = 4'hF, and default N_OUT/N_ACC constants shared with the neuron arrays.
// - One phase counter, sized for max(N_ACC, DRAIN_CYC, SPIKE_CYC, N_OUT), reloaded on every state
//   change. No sub-module; the block is a single FSM with datapath.
// TESTING
// - Reset then start with num_blocks=1, train_mode=1, defaults -> w_rd_en high 128 cycles with addr
//   0..127, 4 idle cycles, gen_spike 3 cycles, outaddr 0..9, new_block at cycle 146, done same cycle.
// - err_vec=10'b1000000101, true_vec=10'h001, both changed to 0 one cycle after FEEDBACK entry ->
//   errspikes high at outaddr 0, 2, 9 and truespikes high only at outaddr 0.
// - num_blocks=3 -> exactly 3 new_block pulses 146 cycles apart, a single done, busy low the next cycle.
// - abort mid-ACCUM at w_addr=40 -> next cycle new_block=1, then IDLE, done never asserted, train=0.
// - start with num_blocks=0 -> behaves as a 1-block run. start pulsed while busy -> ignored.
// - resetn=0 for one cycle during SPIKE -> next cycle all outputs at reset values, outaddr=4'hF.

Source files
------------

// File: rtl/stonet_pkg.sv
// Shared definitions for the stonet hidden-layer control path: FSM states,
// default layer geometry and the idle feedback address.
package stonet_pkg;

  localparam int unsigned N_ACC_DEF     = 128;
  localparam int unsigned DRAIN_CYC_DEF = 4;
  localparam int unsigned SPIKE_CYC_DEF = 3;
  localparam int unsigned N_OUT_DEF     = 10;
  localparam int unsigned AW_DEF        = 7;
  localparam int unsigned NB_W          = 16;
  localparam int unsigned VEC_W         = 10;
  localparam int unsigned OA_W          = 4;

  // Feedback address the neuron decodes as "weight 0"
  localparam logic [OA_W-1:0] OUTADDR_IDLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    SPIKE,
    FEEDBACK,
    COMMIT
  } state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/stonet_block_sequencer_if.sv
// Neuron-array / weight-memory control bus driven by the block sequencer.
interface stonet_block_sequencer_if #(
  parameter int unsigned AW = stonet_pkg::AW_DEF
);
  import stonet_pkg::*;

  logic             w_rd_en;
  logic [AW-1:0]    w_addr;
  logic             gen_spike;
  logic             new_block;
  logic             train;
  logic [OA_W-1:0]  outaddr;
  logic             errspikes;
  logic             truespikes;
  logic [VEC_W-1:0] err_vec;
  logic [VEC_W-1:0] true_vec;

  modport master (
    output w_rd_en, w_addr, gen_spike, new_block, train, outaddr, errspikes, truespikes,
    input  err_vec, true_vec
  );

  modport slave (
    input  w_rd_en, w_addr, gen_spike, new_block, train, outaddr, errspikes, truespikes,
    output err_vec, true_vec
  );

endinterface

// File: rtl/stonet_block_sequencer.sv
// Per-layer block scheduler: accumulate, drain, spike, feedback, commit for each
// image block. Outputs are registered from the next state, so they line up with it.
module stonet_block_sequencer
  import stonet_pkg::*;
#(
  parameter int unsigned N_ACC     = N_ACC_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned SPIKE_CYC = SPIKE_CYC_DEF,
  parameter int unsigned N_OUT     = N_OUT_DEF,
  parameter int unsigned AW        = AW_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [NB_W-1:0]      num_blocks,
  input  logic                 train_mode,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  stonet_block_sequencer_if.master bus
);

  localparam int unsigned PH_MAX = max4(N_ACC, DRAIN_CYC, SPIKE_CYC, N_OUT);
  localparam int unsigned CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned NBX_W  = NB_W + 1;

  state_t           state, nstate;
  logic [CW-1:0]    cnt, ncnt;
  logic [NB_W-1:0]  blk_cnt, nblk;
  logic             end_q, n_end, n_done, last;
  logic [VEC_W-1:0] err_sh, true_sh, err_src, true_src;
  logic [OA_W-1:0]  fb_idx;

  // Wide compare so a count of 16'hFFFF never depends on wrap-around
  assign last     = (NBX_W'(blk_cnt) + NBX_W'(1)) == NBX_W'(nblk);
  assign err_src  = (state == FEEDBACK) ? err_sh  : bus.err_vec;
  assign true_src = (state == FEEDBACK) ? true_sh : bus.true_vec;
  assign fb_idx   = OA_W'(ncnt);

  always_comb begin
    nstate = state;
    ncnt   = cnt + CW'(1);
    n_end  = end_q;
    n_done = 1'b0;
    unique case (state)
      IDLE: begin
        ncnt  = '0;
        n_end = 1'b0;
        if (start) nstate = ACCUM;
      end
      ACCUM:    if (cnt == CW'(N_ACC - 1))     begin nstate = DRAIN;    ncnt = '0; end
      DRAIN:    if (cnt == CW'(DRAIN_CYC - 1)) begin nstate = SPIKE;    ncnt = '0; end
      SPIKE:    if (cnt == CW'(SPIKE_CYC - 1)) begin nstate = FEEDBACK; ncnt = '0; end
      FEEDBACK: if (cnt == CW'(N_OUT - 1)) begin
        nstate = COMMIT;
        ncnt   = '0;
        n_end  = last;
        n_done = last;
      end
      COMMIT: begin
        ncnt   = '0;
        nstate = end_q ? IDLE : ACCUM;
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
    // Abort forces a clearing commit; a commit already in progress just ends the run
    if (abort && (state != IDLE)) begin
      ncnt   = '0;
      n_done = 1'b0;
      if (state == COMMIT) begin
        nstate = IDLE;
      end else begin
        nstate = COMMIT;
        n_end  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      blk_cnt        <= '0;
      nblk           <= '0;
      end_q          <= 1'b0;
      err_sh         <= '0;
      true_sh        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.w_rd_en    <= 1'b0;
      bus.w_addr     <= '0;
      bus.gen_spike  <= 1'b0;
      bus.new_block  <= 1'b0;
      bus.train      <= 1'b0;
      bus.outaddr    <= OUTADDR_IDLE;
      bus.errspikes  <= 1'b0;
      bus.truespikes <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      end_q <= n_end;
      if ((state == IDLE) && start) begin
        blk_cnt <= '0;
        nblk    <= (num_blocks == '0) ? NB_W'(1) : num_blocks;
      end else if ((state == FEEDBACK) && (nstate == COMMIT) && !abort) begin
        blk_cnt <= blk_cnt + NB_W'(1);
      end
      if ((state == SPIKE) && (nstate == FEEDBACK)) begin
        err_sh  <= bus.err_vec;
        true_sh <= bus.true_vec;
      end
      busy           <= (nstate != IDLE);
      done           <= n_done;
      bus.w_rd_en    <= (nstate == ACCUM);
      bus.w_addr     <= (nstate == ACCUM) ? AW'(ncnt) : '0;
      bus.gen_spike  <= (nstate == SPIKE);
      bus.new_block  <= (nstate == COMMIT);
      bus.train      <= (nstate == IDLE) ? 1'b0 : ((state == IDLE) ? train_mode : bus.train);
      bus.outaddr    <= (nstate == FEEDBACK) ? OA_W'(ncnt) : OUTADDR_IDLE;
      bus.errspikes  <= (nstate == FEEDBACK) && err_src[fb_idx];
      bus.truespikes <= (nstate == FEEDBACK) && true_src[fb_idx];
    end
  end

endmodule

// File: tb/tb_stonet_block_sequencer.sv
// Scoreboard bench: each run pushes its expected per-cycle output trace, built
// block by block from the phase lengths; a negedge monitor pops and compares.
module tb_stonet_block_sequencer;
  import stonet_pkg::*;

  localparam int BLK    = int'(N_ACC_DEF + DRAIN_CYC_DEF + SPIKE_CYC_DEF + N_OUT_DEF + 1);
  localparam int FB_POS = int'(N_ACC_DEF + DRAIN_CYC_DEF + SPIKE_CYC_DEF + 1);
  localparam int TIMEOUT_CYC = 200000;

  logic        clk = 1'b0;
  logic        resetn, start, train_mode, abort, busy, done;
  logic [15:0] num_blocks;

  stonet_block_sequencer_if #(.AW(AW_DEF)) bus();

  stonet_block_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .num_blocks (num_blocks),
    .train_mode (train_mode),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              w_rd_en;
    logic [AW_DEF-1:0] w_addr;
    logic              gen_spike;
    logic              new_block;
    logic              train;
    logic [3:0]        outaddr;
    logic              errspikes;
    logic              truespikes;
    logic              busy;
    logic              done;
  } out_t;

  out_t       exp_q[$];
  out_t       e, a;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  bit         sim_done = 1'b0;
  logic [9:0] errs[4];
  logic [9:0] trues[4];

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.outaddr = 4'hF;
    return o;
  endfunction

  function automatic out_t run_out(input bit tm);
    out_t o;
    o = idle_out();
    o.busy  = 1'b1;
    o.train = tm;
    return o;
  endfunction

  function automatic out_t sample_out();
    out_t s;
    s.w_rd_en    = bus.w_rd_en;
    s.w_addr     = bus.w_addr;
    s.gen_spike  = bus.gen_spike;
    s.new_block  = bus.new_block;
    s.train      = bus.train;
    s.outaddr    = bus.outaddr;
    s.errspikes  = bus.errspikes;
    s.truespikes = bus.truespikes;
    s.busy       = busy;
    s.done       = done;
    return s;
  endfunction

  // Full-output comparison against the reset/idle values
  task automatic check_idle(input string tag);
    out_t s;
    s = sample_out();
    n_cmp++;
    if (s !== idle_out()) begin
      n_err++;
      $display("FAIL %s t=%0t got rd=%b a=%0d gs=%b nb=%b tr=%b oa=%h es=%b ts=%b busy=%b done=%b",
               tag, $time, s.w_rd_en, s.w_addr, s.gen_spike, s.new_block, s.train, s.outaddr,
               s.errspikes, s.truespikes, s.busy, s.done);
    end
  endtask

  // Expected trace of one run; ca = abort cycle, cr = reset cycle (0 = none)
  task automatic build(input int nb_eff, input bit tm, input int ca, input int cr);
    out_t q[$];
    out_t o;
    int   lim;
    lim = (ca > 0) ? ca : ((cr > 0) ? cr : nb_eff * BLK);
    for (int b = 0; (b < nb_eff) && (q.size() < lim); b++) begin
      for (int i = 0; i < int'(N_ACC_DEF); i++) begin
        o = run_out(tm); o.w_rd_en = 1'b1; o.w_addr = AW_DEF'(i); q.push_back(o);
      end
      for (int i = 0; i < int'(DRAIN_CYC_DEF); i++) q.push_back(run_out(tm));
      for (int i = 0; i < int'(SPIKE_CYC_DEF); i++) begin
        o = run_out(tm); o.gen_spike = 1'b1; q.push_back(o);
      end
      for (int k = 0; k < int'(N_OUT_DEF); k++) begin
        o = run_out(tm);
        o.outaddr    = 4'(k);
        o.errspikes  = errs[b % 4][k];
        o.truespikes = trues[b % 4][k];
        q.push_back(o);
      end
      o = run_out(tm); o.new_block = 1'b1; o.done = (b == nb_eff - 1); q.push_back(o);
    end
    while (q.size() > lim) void'(q.pop_back());
    if (ca > 0) begin
      o = run_out(tm); o.new_block = 1'b1; q.push_back(o);
    end
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic run(input logic [15:0] nb, input bit tm, input int ca, input int cr,
                     input bit abort_with_start, input bit junk_start);
    int nb_eff, len, b, p;
    nb_eff     = (nb == 16'd0) ? 1 : int'(nb);
    start      = 1'b1;
    num_blocks = nb;
    train_mode = tm;
    abort      = abort_with_start;
    bus.err_vec  = errs[0];
    bus.true_vec = trues[0];
    @(posedge clk); #1;
    build(nb_eff, tm, ca, cr);
    len = (ca > 0) ? ca + 1 : ((cr > 0) ? cr : nb_eff * BLK);
    for (int c = 1; c <= len; c++) begin
      b = (c - 1) / BLK;
      p = (c - 1) % BLK + 1;
      start      = junk_start ? ($urandom_range(0, 7) == 0) : 1'b0;
      num_blocks = 16'($urandom);
      train_mode = 1'($urandom);
      abort      = (c == ca);
      resetn     = !(c == cr);
      if (p <= FB_POS) begin
        bus.err_vec  = errs[b % 4];
        bus.true_vec = trues[b % 4];
      end else begin
        bus.err_vec  = 10'($urandom);
        bus.true_vec = 10'($urandom);
      end
      @(posedge clk); #1;
    end
    start  = 1'b0;
    abort  = 1'b0;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      abort = 1'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < 4; i++) begin
      errs[i]  = 10'($urandom);
      trues[i] = 10'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = idle_out();
      a = sample_out();
      // Address is only meaningful while the read strobe is expected
      if (!e.w_rd_en) a.w_addr = e.w_addr;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL out_trace t=%0t got{rd=%b a=%0d gs=%b nb=%b tr=%b oa=%h es=%b ts=%b busy=%b done=%b} exp{rd=%b a=%0d gs=%b nb=%b tr=%b oa=%h es=%b ts=%b busy=%b done=%b}",
                 $time, a.w_rd_en, a.w_addr, a.gen_spike, a.new_block, a.train, a.outaddr,
                 a.errspikes, a.truespikes, a.busy, a.done, e.w_rd_en, e.w_addr, e.gen_spike,
                 e.new_block, e.train, e.outaddr, e.errspikes, e.truespikes, e.busy, e.done);
      end
    end
  end

  // Watchdog: the whole sequence must finish within a bounded number of cycles
  initial begin
    int cyc;
    cyc = 0;
    while (!sim_done && (cyc < TIMEOUT_CYC)) begin
      @(posedge clk);
      cyc++;
    end
    if (!sim_done) begin
      n_err++;
      $display("FAIL timeout: sequence not finished after %0d cycles", TIMEOUT_CYC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    logic [15:0] nb;
    int          ca;
    resetn       = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    num_blocks   = '0;
    train_mode   = 1'b0;
    bus.err_vec  = '0;
    bus.true_vec = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_idle("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single training block with known feedback vectors
    rand_vecs();
    errs[0]  = 10'b1000000101;
    trues[0] = 10'h001;
    run(16'd1, 1'b1, 0, 0, 1'b0, 1'b0);
    // Three blocks, distinct feedback per block
    rand_vecs();
    run(16'd3, 1'b0, 0, 0, 1'b0, 1'b0);
    // Abort while w_addr = 40 is presented
    rand_vecs();
    run(16'd1, 1'b1, 41, 0, 1'b0, 1'b0);
    // Zero count acts as one block; start pulses while busy are ignored
    rand_vecs();
    run(16'd0, 1'b1, 0, 0, 1'b0, 1'b1);
    // One-cycle reset during the spike phase
    rand_vecs();
    run(16'd2, 1'b1, 0, 134, 1'b0, 1'b0);
    // start and abort together in IDLE: start wins
    rand_vecs();
    run(16'd1, 1'b0, 0, 0, 1'b1, 1'b0);
    // Maximum count must not end early; abort in the third block
    rand_vecs();
    run(16'hFFFF, 1'b1, 2 * BLK + 60, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rand_vecs();
      nb = 16'($urandom_range(0, 3));
      ca = 0;
      if ($urandom_range(0, 2) == 0) begin
        ca = $urandom_range(1, ((nb == 16'd0) ? 1 : int'(nb)) * BLK - 1);
        if (ca % BLK == 0) ca = ca - 1;
      end
      run(nb, 1'($urandom), ca, 0, 1'($urandom), 1'b1);
    end

    repeat (5) begin @(posedge clk); #1; end
    check_idle("final_idle");
    mon_en   = 1'b0;
    sim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
